pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. It holds the current fetch address and selects the next one from reset vector, trap redirect, resolved jump/branch redirect, branch-target-buffer prediction or sequential +4. It sits at the head of the pipeline, driving the instruction-memory address, and takes redirect and BTB-training inputs from the execute/trap logic.

---
 rtl/pc_gen.sv | 101 ++++++++++
 tb/tb_pc_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter with an optional direct-mapped branch target buffer.
// Define PC_BTB_EN to build the BTB; without it, prediction outputs are tied low.
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter int               BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            jp_en,
  input  logic [XLEN-1:0] jp_addr,
  input  logic            bu_en,
  input  logic [XLEN-1:0] bu_pc,
  input  logic [XLEN-1:0] bu_target,
  input  logic            bu_taken,
  output logic [XLEN-1:0] addr,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] addr_q, addr_d;

  // Stall outranks every redirect; a redirect seen while stalled is simply not taken.
  always_comb begin
    addr_d = addr_q;
    if (!stall) begin
      if (trap_en)         addr_d = trap_addr;
      else if (jp_en)      addr_d = jp_addr;
      else if (pred_taken) addr_d = pred_target;
      else                 addr_d = addr_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= RESET_VEC;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;

`ifdef PC_BTB_EN
  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDX - 2;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAGW-1:0]      tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
  logic [1:0]           ctr_q [BTB_DEPTH];

  logic [IDX-1:0]  l_idx, u_idx;
  logic [TAGW-1:0] l_tag, u_tag;
  logic            l_hit, u_hit;
  logic            unused_lsb;

  assign l_idx = addr_q[IDX+1:2];
  assign l_tag = addr_q[XLEN-1:IDX+2];
  assign u_idx = bu_pc[IDX+1:2];
  assign u_tag = bu_pc[XLEN-1:IDX+2];
  assign unused_lsb = ^bu_pc[1:0];

  assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = l_hit && ctr_q[l_idx][1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : '0;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk) begin
    if (rst)                          valid_q <= '0;
    else if (bu_en && bu_taken && !u_hit) valid_q[u_idx] <= 1'b1;
  end

  // Payload is not reset; writes are suppressed during reset so training is dropped.
  always_ff @(posedge clk) begin
    if (!rst && bu_en) begin
      if (u_hit) begin
        if (bu_taken) begin
          ctr_q[u_idx] <= (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
          tgt_q[u_idx] <= bu_target;
        end else begin
          ctr_q[u_idx] <= (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
        end
      end else if (bu_taken) begin
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= bu_target;
        ctr_q[u_idx] <= 2'd2;
      end
    end
  end
`else
  localparam int UNUSED_DEPTH = BTB_DEPTH;
  logic unused_bu;

  assign unused_bu   = ^{bu_en, bu_pc, bu_target, bu_taken, UNUSED_DEPTH[0]};
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations queued per step, popped and checked after each edge.
module tb_pc_gen;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, stall, trap_en, jp_en, bu_en, bu_taken;
  logic [XLEN-1:0] trap_addr, jp_addr, bu_pc, bu_target;
  logic [XLEN-1:0] addr, pred_target;
  logic            pred_taken;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] a;
    logic            pt;
    logic [XLEN-1:0] tg;
  } exp_t;
  exp_t q[$];

  pc_gen #(.XLEN(XLEN), .RESET_VEC(32'h100), .BTB_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .trap_en(trap_en), .trap_addr(trap_addr),
    .jp_en(jp_en), .jp_addr(jp_addr),
    .bu_en(bu_en), .bu_pc(bu_pc), .bu_target(bu_target), .bu_taken(bu_taken),
    .addr(addr), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // Inputs are already set; queue what the next edge must produce, then check it.
  task automatic cyc(input string tag, input logic [XLEN-1:0] ea,
                     input logic ept, input logic [XLEN-1:0] etg);
    exp_t e;
    q.push_back('{tag, ea, ept, etg});
    @(posedge clk);
    #1;
    e = q.pop_front();
    total++;
    assert (addr === e.a) else begin
      bad++;
      $error("FAIL %s addr got=%h exp=%h", e.tag, addr, e.a);
    end
    total++;
    assert (pred_taken === e.pt) else begin
      bad++;
      $error("FAIL %s pred_taken got=%b exp=%b", e.tag, pred_taken, e.pt);
    end
    total++;
    assert (pred_target === e.tg) else begin
      bad++;
      $error("FAIL %s pred_target got=%h exp=%h", e.tag, pred_target, e.tg);
    end
  endtask

  initial begin
    rst = 1; stall = 0; trap_en = 0; jp_en = 0; bu_en = 0; bu_taken = 0;
    trap_addr = '0; jp_addr = '0; bu_pc = '0; bu_target = '0;

    cyc("reset0", 32'h100, 0, 0);
    cyc("reset1", 32'h100, 0, 0);
    rst = 0;
    cyc("seq1", 32'h104, 0, 0);
    cyc("seq2", 32'h108, 0, 0);
    cyc("seq3", 32'h10C, 0, 0);

    jp_en = 1; jp_addr = 32'hFFFF_FFFC;
    cyc("wrap_jp", 32'hFFFF_FFFC, 0, 0);
    jp_en = 0;
    cyc("wrap0", 32'h0, 0, 0);

    stall = 1; trap_en = 1; trap_addr = 32'h200; jp_en = 1; jp_addr = 32'h300;
    cyc("stall_hold0", 32'h0, 0, 0);
    cyc("stall_hold1", 32'h0, 0, 0);
    stall = 0;
    cyc("trap_wins", 32'h200, 0, 0);
    trap_en = 0;
    cyc("jp_alone", 32'h300, 0, 0);
    jp_en = 0;
    cyc("after_jp", 32'h304, 0, 0);
    stall = 1;
    cyc("stall_only", 32'h304, 0, 0);
    stall = 0;
    cyc("unstall", 32'h308, 0, 0);

    rst = 1;
    cyc("mid_rst", 32'h100, 0, 0);
    rst = 0;
    cyc("post_rst", 32'h104, 0, 0);

    // Train 0x20 -> 0x80 while jumping to 0x1C (a different BTB index).
    jp_en = 1; jp_addr = 32'h1C;
    bu_en = 1; bu_pc = 32'h20; bu_target = 32'h80; bu_taken = 1;
    cyc("train", 32'h1C, 0, 0);
    jp_en = 0; bu_en = 0;
`ifdef PC_BTB_EN
    cyc("pred_hit", 32'h20, 1, 32'h80);
    cyc("pred_follow", 32'h80, 0, 0);
    bu_en = 1; bu_taken = 0;
    cyc("nt1", 32'h84, 0, 0);
    cyc("nt2", 32'h88, 0, 0);
    bu_en = 0; jp_en = 1; jp_addr = 32'h20;
    cyc("pred_off", 32'h20, 0, 0);
    jp_en = 0;
    cyc("pred_off_seq", 32'h24, 0, 0);

    // Counter is at 0: two taken updates reach weak-taken; 0x60 aliases index 8.
    bu_en = 1; bu_taken = 1; jp_en = 1; jp_addr = 32'h60;
    cyc("alias0", 32'h60, 0, 0);
    cyc("alias1", 32'h60, 0, 0);
    bu_en = 0; jp_addr = 32'h20;
    cyc("retrained", 32'h20, 1, 32'h80);
    jp_en = 0;
    rst = 1; bu_en = 1; bu_taken = 1;
    cyc("rst_clear", 32'h100, 0, 0);
    rst = 0; bu_en = 0; jp_en = 1;
    cyc("rst_no_pred", 32'h20, 0, 0);
    jp_en = 0;
    cyc("rst_no_pred_seq", 32'h24, 0, 0);
`else
    cyc("nobtb_0x20", 32'h20, 0, 0);
    cyc("nobtb_seq", 32'h24, 0, 0);
    bu_en = 1; bu_taken = 1;
    cyc("nobtb_train2", 32'h28, 0, 0);
    bu_en = 0;
    cyc("nobtb_seq2", 32'h2C, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
